data_ram: RTL
=============

// Module: data_ram
// PURPOSE
//  Data-memory responder for the core's RAM port (ram_addr_o/ram_data_o/ram_we_o/ram_sel_o/ram_ce_o).
//  Byte-lane-masked synchronous writes and same-cycle combinational reads feed the MEM stage.
//  Adds sticky access-fault capture and saturating access counters for bring-up and debug.
//  Sits beside the core in the SoC top, one instance per data port.
// PARAMETERS
//  ADDR_W     10            log2 of depth in 32-bit words (1024 words = 4 KiB)
//  BASE_ADDR  32'h0000_0000 byte base address of the array; bits [1:0] must be 0
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  ce           in   1   access request this cycle (core ram_ce_o)
//  we           in   1   1 = write, 0 = read (core ram_we_o)
//  addr         in   32  byte address (core ram_addr_o)
//  sel          in   4   byte-lane select; sel[i] <-> data bits [8i+7:8i]
//  data_i       in   32  write data (core ram_data_o)
//  data_o       out  32  read data (to core ram_data_i), combinational
//  err_o        out  1   sticky fault flag
//  fault_addr_o out  32  address of first fault since last clear
//  fault_type_o out  2   01 out-of-range, 10 sel/align mismatch, 11 null write (we=1, sel=0)
//  err_clr_i    in   1   synchronous clear of err_o / fault_addr_o / fault_type_o
//  rd_cnt_o     out  16  accepted reads, saturates at 16'hFFFF
//  wr_cnt_o     out  16  accepted writes, saturates at 16'hFFFF
// BEHAVIOUR
//  Index: idx = addr[31:2] - BASE_ADDR[31:2]. In range iff idx < 2**ADDR_W (30-bit unsigned compare).
//  Legal sel vs addr[1:0] (big-endian, offset 0 = lane 3):
//   1111@00; 1100@00; 0011@10; 1000@00; 0100@01; 0010@10; 0001@11. Anything else is a mismatch.
//  Fault priority when ce=1: out-of-range > null write > sel/align mismatch. No fault when ce=0.
//  Accepted access: ce=1 and no fault.
//  Write: accepted write updates only lanes with sel[i]=1 at the next rising edge; other lanes hold.
//  Read: data_o = mem[idx] when ce=1, we=0, accepted; otherwise 32'h0. Zero-latency, same cycle.
//   Read of a word written at the same edge shows the new value from the following cycle only.
//   Lanes not selected in a read are still driven from mem; the core extracts the lanes it needs.
//  Fault capture (registered, visible the cycle after the faulting access):
//   - err_o=0 and fault: err_o<=1, fault_addr_o<=addr, fault_type_o<=type.
//   - err_o=1: further faults are ignored and the first capture is held.
//   - err_clr_i=1 with no fault: all three are cleared.
//   - err_clr_i=1 with a fault in the same cycle: the new fault is captured (the fault wins).
//  Faulting write: memory is unchanged. Faulting read: data_o=0. Counters do not increment.
//  Counters: +1 per cycle with an accepted read or write, held at 16'hFFFF once reached.
//  Reset (asynchronous): err_o=0, fault_addr_o=0, fault_type_o=0, rd_cnt_o=0, wr_cnt_o=0.
//   Array contents are not reset and are undefined until written.
//   data_o follows its combinational rule, and is 0 whenever ce=0.
//   No write occurs at any edge while rst_n=0. A write in flight when reset asserts is dropped.
//  Array is inferable as single-port RAM with byte enables and asynchronous read.
// TESTING
//  T1 write 32'hDEADBEEF @0x10 sel=1111, then read @0x10 -> data_o=DEADBEEF next cycle; wr_cnt=1, rd_cnt=1
//  T2 byte write 8'h5A @0x11 sel=0100 over DEADBEEF, read word @0x10 -> DE5ABEEF;
//     half 0x1234 @0x12 sel=0011 -> DE5A1234
//  T3 read @0x11 sel=1000 -> data_o=0, err_o=1 next cycle, fault_type=10, fault_addr=0x11;
//     second fault @0x2000 does not change the captured values
//  T4 write @(BASE+4*2**ADDR_W) sel=1111 -> memory unchanged, fault_type=01, wr_cnt unchanged;
//     err_clr_i and a new null-write fault in the same cycle -> fault_type=11
//  T5 preload wr_cnt by 65535 accepted writes, one more write -> wr_cnt stays 16'hFFFF
//  T6 assert rst_n=0 mid-write with ce=we=1 -> target word unchanged after release;
//     all status outputs and counters read 0

Source files
------------

// File: rtl/data_ram_if.sv
// Core-side data-memory bus: request, address, byte lanes and read/write data.
// The core drives the master side and data_ram answers on the slave side.
interface data_ram_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output ce, we, addr, sel, data_i, input data_o);
  modport slave  (input ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/data_ram.sv
// Byte-lane data RAM with combinational read, sticky first-fault capture
// and saturating read/write access counters.
module data_ram #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    data_ram_if.slave   bus,
    input  logic        err_clr_i,
    output logic        err_o,
    output logic [31:0] fault_addr_o,
    output logic [1:0]  fault_type_o,
    output logic [15:0] rd_cnt_o,
    output logic [15:0] wr_cnt_o
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        FAULT_NONE  = 2'b00,
        FAULT_RANGE = 2'b01,
        FAULT_ALIGN = 2'b10,
        FAULT_NULL  = 2'b11
    } fault_e;

    logic [31:0]       mem [DEPTH];
    logic [29:0]       idx;
    logic [ADDR_W-1:0] widx;
    logic              in_range;
    logic              sel_ok;
    fault_e            fault;
    logic              accept;

    assign idx      = bus.addr[31:2] - BASE_ADDR[31:2];
    assign widx     = idx[ADDR_W-1:0];
    assign in_range = idx < 30'(DEPTH);

    // Big-endian lane map: byte offset 0 lives in lane 3.
    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        sel_ok = 1'b0;
        case ({bus.sel, bus.addr[1:0]})
            6'b1111_00, 6'b1100_00, 6'b0011_10,
            6'b1000_00, 6'b0100_01, 6'b0010_10, 6'b0001_11: sel_ok = 1'b1;
            default:                                         sel_ok = 1'b0;
        endcase
    end

    always_comb begin
        fault = FAULT_NONE;
        if (bus.ce) begin
            if (!in_range)                   fault = FAULT_RANGE;
            else if (bus.we && bus.sel == '0) fault = FAULT_NULL;
            else if (!sel_ok)                fault = FAULT_ALIGN;
        end
    end

    assign accept     = bus.ce && (fault == FAULT_NONE);
    assign bus.data_o = (accept && !bus.we) ? mem[widx] : 32'h0;

    // NOTE: the array has no reset so it maps onto RAM; gating on rst_n drops writes while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && accept && bus.we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.sel[i]) mem[widx][8*i +: 8] <= bus.data_i[8*i +: 8];
            end
        end
    end

    // A fault arriving with err_clr_i wins over the clear.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o        <= 1'b0;
            fault_addr_o <= 32'h0;
            fault_type_o <= 2'b00;
            rd_cnt_o     <= 16'h0;
            wr_cnt_o     <= 16'h0;
        end else begin
            if (fault != FAULT_NONE && (!err_o || err_clr_i)) begin
                err_o        <= 1'b1;
                fault_addr_o <= bus.addr;
                fault_type_o <= fault;
            end else if (err_clr_i) begin
                err_o        <= 1'b0;
                fault_addr_o <= 32'h0;
                fault_type_o <= 2'b00;
            end

            if (accept && !bus.we && rd_cnt_o != 16'hFFFF) rd_cnt_o <= rd_cnt_o + 16'd1;
            if (accept &&  bus.we && wr_cnt_o != 16'hFFFF) wr_cnt_o <= wr_cnt_o + 16'd1;
        end
    end

endmodule
